// File: rtl/timer_unit_tick_counter.sv
// timer_unit_tick_counter
// Main counting stage of the timer unit. Counts events from one of three
// sources (every clk_i, prescaler tick, synchronised ref_clk_i rising edge)
// against a compare value and emits a one-cycle interrupt on each match.
// Supports continuous and one-shot modes via a small IDLE/RUN/STOP FSM.
module timer_unit_tick_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_enable_i,
  input  logic                 cfg_mode_i,
  input  logic                 cfg_cmp_clr_i,
  input  logic [1:0]           cfg_src_i,
  input  logic                 presc_tick_i,
  input  logic                 ref_clk_i,
  input  logic                 write_counter_i,
  input  logic [CNT_WIDTH-1:0] counter_value_i,
  input  logic                 reset_count_i,
  input  logic [CNT_WIDTH-1:0] compare_value_i,
  output logic [CNT_WIDTH-1:0] counter_value_o,
  output logic                 irq_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [1:0] SRC_CLK  = 2'd0;
  localparam logic [1:0] SRC_PRSC = 2'd1;
  localparam logic [1:0] SRC_REF  = 2'd2;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   irq_q;
  logic                   busy_q;

  // ref_clk_i is asynchronous: two synchroniser stages, then an edge flop
  // holding the previous synchronised level.
  logic                   ref_sync_q1, ref_sync_q2, ref_edge_q;
  logic                   ref_tick;

  logic                   src_event;
  logic                   tick;
  logic                   cmp_hit;
  logic                   match;

  // Synchronise ref_clk_i into the clk_i domain and keep one cycle of history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_sync_q1 <= 1'b0;
      ref_sync_q2 <= 1'b0;
      ref_edge_q  <= 1'b0;
    end else begin
      ref_sync_q1 <= ref_clk_i;
      ref_sync_q2 <= ref_sync_q1;
      ref_edge_q  <= ref_sync_q2;
    end
  end

  // One-cycle pulse on each synchronised rising edge of ref_clk_i.
  assign ref_tick = ref_sync_q2 & ~ref_edge_q;

  // Select the count event source; source 3 is a deliberate "no events".
  always_comb begin
    src_event = 1'b0;
    unique case (cfg_src_i)
      SRC_CLK:  src_event = 1'b1;
      SRC_PRSC: src_event = presc_tick_i;
      SRC_REF:  src_event = ref_tick;
      default:  src_event = 1'b0;
    endcase
  end

  // Events only count while running; software strobes suppress a match so
  // a load/clear on the same cycle never raises a spurious interrupt.
  assign tick    = src_event & (state_q == RUN);
  assign cmp_hit = (count_q == compare_value_i);
  assign match   = tick & cmp_hit & ~reset_count_i & ~write_counter_i;

  // Next-state logic for the run control FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable_i) state_d = RUN;
      end
      RUN: begin
        // Disable takes precedence over a one-shot completion.
        if (!cfg_enable_i)          state_d = IDLE;
        else if (match && cfg_mode_i) state_d = STOP;
      end
      STOP: begin
        if (!cfg_enable_i)     state_d = IDLE;
        else if (reset_count_i) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter next value: software clear, software load, clear-on-match,
  // increment (wrapping naturally), else hold.
  always_comb begin
    count_d = count_q;
    if (reset_count_i)               count_d = '0;
    else if (write_counter_i)        count_d = counter_value_i;
    else if (match && cfg_cmp_clr_i) count_d = '0;
    else if (tick)                   count_d = count_q + 1'b1;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      irq_q   <= match;
      busy_q  <= (state_d == RUN);
    end
  end

  assign counter_value_o = count_q;
  assign irq_o           = irq_q;
  assign busy_o          = busy_q;

endmodule
